// File: rtl/fifo_rd_stream_if.sv
// Bundle of FIFO read-port and valid/ready stream signals for fifo_rd_stream.
// Optional rd_cnt signal (and CNT_W) present only when FIFO_RD_CNT_EN is defined.
interface fifo_rd_stream_if #(
    parameter int unsigned WIDTH = 8
`ifdef FIFO_RD_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_q;
    logic             fifo_rd;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             idle;
`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] rd_cnt;
`endif

    // Adapter side: consumes FIFO flags/data and consumer ready, drives the stream
    modport master (
        input  fifo_empty,
        input  fifo_q,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data,
        output idle
`ifdef FIFO_RD_CNT_EN
        , output rd_cnt
`endif
    );

    modport slave (
        output fifo_empty,
        output fifo_q,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data,
        input  idle
`ifdef FIFO_RD_CNT_EN
        , input rd_cnt
`endif
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: issues pops, hides 1-cycle read latency in a 2-entry skid buffer.
// Define FIFO_RD_CNT_EN to add the rd_cnt delivered-word counter (width CNT_W).
module fifo_rd_stream #(
    parameter int unsigned WIDTH = 8
`ifdef FIFO_RD_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    fifo_rd_stream_if.master    bus
);
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             inflight_q;
    logic             valid_q;
    logic             head_q;
    logic             tail_q;
    logic [WIDTH-1:0] buf_q [2];

    logic             pop_c;
    logic [2:0]       level_c;
    logic             rd_c;

    // Words committed after this edge decide whether another pop fits
    always_comb begin
        pop_c   = valid_q & bus.m_ready;
        level_c = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
        rd_c    = !bus.fifo_empty && (level_c < 3'd2);
        occ_d   = level_c[1:0];
    end

    assign bus.fifo_rd = rd_c;
    assign bus.m_valid = valid_q;
    assign bus.m_data  = buf_q[head_q];
    assign bus.idle    = (occ_q == 2'd0) && !inflight_q && bus.fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= rd_c;
            valid_q    <= (occ_d != 2'd0);
            // Returning FIFO word lands at the tail; with an empty buffer tail == head
            if (inflight_q) begin
                buf_q[tail_q] <= bus.fifo_q;
                tail_q        <= ~tail_q;
            end
            if (pop_c) begin
                head_q <= ~head_q;
            end
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [CNT_W-1:0] rd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else if (pop_c) begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end
    end

    assign bus.rd_cnt = rd_cnt_q;
`endif
endmodule
